// File: rtl/trigger_per_mc.sv
// ============================================================================
//  Module   : trigger_per_mc
//  Purpose  : Multi-channel periodic trigger generator. Each channel has a
//             start delay, high/low phase widths and a burst pulse count
//             (0 = continuous), with a burst-complete flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trigger_per_mc #(
  parameter int N_CH = 4,
  parameter int CW   = 16,
  parameter int NW   = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [N_CH-1:0]      start,
  output logic [N_CH-1:0]      trigger,
  output logic [N_CH-1:0]      done,
  input  logic [N_CH*CW-1:0]   DELAY_REG,
  input  logic [N_CH*CW-1:0]   WIDTH_HI_REG,
  input  logic [N_CH*CW-1:0]   WIDTH_LO_REG,
  input  logic [N_CH*NW-1:0]   COUNT_REG
);

  // One-hot channel states
  localparam logic [4:0] c_ST_IDLE  = 5'b00001;
  localparam logic [4:0] c_ST_DELAY = 5'b00010;
  localparam logic [4:0] c_ST_HIGH  = 5'b00100;
  localparam logic [4:0] c_ST_LOW   = 5'b01000;
  localparam logic [4:0] c_ST_DONE  = 5'b10000;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [4:0]    r_state;
      logic [CW-1:0] r_cnt;
      logic [NW-1:0] r_pulse_cnt;
      logic [CW-1:0] r_delay;
      logic [CW-1:0] r_hi;
      logic [CW-1:0] r_lo;
      logic [NW-1:0] r_count;

      logic [CW-1:0] w_delay_last;
      logic [NW-1:0] w_pulse_next;
      logic          w_last_pulse;

      // DELAY lasts exactly r_delay cycles, so its terminal count is r_delay-1;
      // only used in DELAY, where r_delay is known to be nonzero.
      assign w_delay_last = r_delay - CW'(1);
      assign w_pulse_next = r_pulse_cnt + NW'(1);
      assign w_last_pulse = (r_count != '0) && (w_pulse_next == r_count);

      // Shadow copies follow the register bank only while idle, so writes
      // during a run apply to the next run.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_delay <= '0;
          r_hi    <= '0;
          r_lo    <= '0;
          r_count <= '0;
        end else if (r_state == c_ST_IDLE) begin
          r_delay <= DELAY_REG[gi*CW +: CW];
          r_hi    <= WIDTH_HI_REG[gi*CW +: CW];
          r_lo    <= WIDTH_LO_REG[gi*CW +: CW];
          r_count <= COUNT_REG[gi*NW +: NW];
        end
      end

      // Channel FSM with phase and pulse counters; dropping start aborts
      // from any state, taking priority over terminal counts.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_state     <= c_ST_IDLE;
          r_cnt       <= '0;
          r_pulse_cnt <= '0;
        end else if ((r_state != c_ST_IDLE) && !start[gi]) begin
          r_state     <= c_ST_IDLE;
          r_cnt       <= '0;
          r_pulse_cnt <= '0;
        end else begin
          case (r_state)
            c_ST_IDLE: begin
              r_cnt       <= '0;
              r_pulse_cnt <= '0;
              if (start[gi]) begin
                r_state <= (r_delay != '0) ? c_ST_DELAY : c_ST_HIGH;
              end
            end
            c_ST_DELAY: begin
              if (r_cnt == w_delay_last) begin
                r_cnt   <= '0;
                r_state <= c_ST_HIGH;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            c_ST_HIGH: begin
              if (r_cnt == r_hi) begin
                r_cnt       <= '0;
                r_pulse_cnt <= w_pulse_next;
                // The last pulse of a burst goes straight to DONE.
                r_state     <= w_last_pulse ? c_ST_DONE : c_ST_LOW;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            c_ST_LOW: begin
              if (r_cnt == r_lo) begin
                r_cnt   <= '0;
                r_state <= c_ST_HIGH;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            c_ST_DONE: begin
              r_state <= c_ST_DONE;
            end
            default: begin
              r_state     <= c_ST_IDLE;
              r_cnt       <= '0;
              r_pulse_cnt <= '0;
            end
          endcase
        end
      end

      assign trigger[gi] = (r_state == c_ST_HIGH);
      assign done[gi]    = (r_state == c_ST_DONE);
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_trigger_per_mc.sv
// ============================================================================
//  Module   : tb_trigger_per_mc
//  Purpose  : Self-checking bench for trigger_per_mc (vector table plus
//             hand-written multi-cycle sequences).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trigger_per_mc;
  localparam int N_CH = 4;
  localparam int CW   = 16;
  localparam int NW   = 16;

  logic                aclk = 1'b0;
  logic                aresetn = 1'b0;
  logic [N_CH-1:0]     start = '0;
  logic [N_CH-1:0]     trigger;
  logic [N_CH-1:0]     done;
  logic [N_CH*CW-1:0]  DELAY_REG = '0;
  logic [N_CH*CW-1:0]  WIDTH_HI_REG = '0;
  logic [N_CH*CW-1:0]  WIDTH_LO_REG = '0;
  logic [N_CH*NW-1:0]  COUNT_REG = '0;

  int total = 0;
  int bad   = 0;

  trigger_per_mc #(.N_CH(N_CH), .CW(CW), .NW(NW)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .start        (start),
    .trigger      (trigger),
    .done         (done),
    .DELAY_REG    (DELAY_REG),
    .WIDTH_HI_REG (WIDTH_HI_REG),
    .WIDTH_LO_REG (WIDTH_LO_REG),
    .COUNT_REG    (COUNT_REG)
  );

  always #5 aclk = ~aclk;

  // Vector record: channel config plus expected per-cycle trigger/done
  // strings; character c is the value sampled c cycles after start rises.
  typedef struct {
    string name;
    int    ch;
    int    dly;
    int    hi;
    int    lo;
    int    cnt;
    string trig;
    string dn;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic cfg(input int ch, input int dly, input int hi, input int lo, input int cnt);
    DELAY_REG[ch*CW +: CW]    = CW'(dly);
    WIDTH_HI_REG[ch*CW +: CW] = CW'(hi);
    WIDTH_LO_REG[ch*CW +: CW] = CW'(lo);
    COUNT_REG[ch*NW +: NW]    = NW'(cnt);
  endtask

  initial begin
    logic [N_CH-1:0] e_t;
    logic [N_CH-1:0] e_d;

    tbl[0] = '{"cont_h2_l3",   0, 0, 2, 3, 0, "111000011100001110000", "000000000000000000000"};
    tbl[1] = '{"burst_d5_x3",  0, 5, 0, 1, 3, "0000010010010000",      "0000000000001111"};
    tbl[2] = '{"ch1_d2_x2",    1, 2, 1, 4, 2, "00110000011000",        "00000000000111"};
    tbl[3] = '{"ch2_single",   2, 0, 0, 2, 1, "10000",                 "01111"};
    tbl[4] = '{"ch3_d1_x2",    3, 1, 1, 0, 2, "0110110000",            "0000001111"};

    // Reset state
    #3;
    chk("reset_trig", 32'(trigger), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    tick;
    #2 aresetn = 1'b1;
    tick;

    // Table-driven vectors, one channel at a time
    for (int i = 0; i < 5; i++) begin
      cfg(tbl[i].ch, tbl[i].dly, tbl[i].hi, tbl[i].lo, tbl[i].cnt);
      start = '0;
      tick; tick; tick;
      start[tbl[i].ch] = 1'b1;
      for (int c = 0; c < tbl[i].trig.len(); c++) begin
        tick;
        e_t = '0;
        e_d = '0;
        e_t[tbl[i].ch] = (tbl[i].trig[c] == "1");
        e_d[tbl[i].ch] = (tbl[i].dn[c] == "1");
        chk($sformatf("%s trig c%0d", tbl[i].name, c), 32'(trigger), 32'(e_t));
        chk($sformatf("%s done c%0d", tbl[i].name, c), 32'(done), 32'(e_d));
      end
      start = '0;
      tick;
      chk($sformatf("%s abort_trig", tbl[i].name), 32'(trigger), 32'h0);
      chk($sformatf("%s abort_done", tbl[i].name), 32'(done), 32'h0);
    end

    // Mid-run width change is ignored until the channel idles
    cfg(0, 0, 2, 3, 0);
    tick; tick;
    start[0] = 1'b1;
    for (int c = 0; c < 21; c++) begin
      tick;
      chk($sformatf("midwrite_old c%0d", c), 32'(trigger[0]), 32'((c % 7) < 3));
      if (c == 2) cfg(0, 0, 7, 3, 0);
    end
    start = '0;
    tick; tick;
    start[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      chk($sformatf("midwrite_new c%0d", c), 32'(trigger[0]), 32'(c < 8));
    end
    start = '0;
    cfg(0, 0, 2, 3, 0);
    tick; tick;

    // Abort on the second HIGH cycle, then restart with a full pulse
    start[0] = 1'b1;
    tick;
    chk("abort_hi0", 32'(trigger[0]), 32'h1);
    tick;
    chk("abort_hi1", 32'(trigger[0]), 32'h1);
    start[0] = 1'b0;
    tick;
    chk("abort_low", 32'(trigger[0]), 32'h0);
    start[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      chk($sformatf("restart c%0d", c), 32'(trigger[0]), 32'(c < 3));
    end
    start = '0;
    tick; tick;

    // Two channels started together run independently
    cfg(0, 0, 0, 0, 0);
    cfg(1, 2, 1, 4, 2);
    tick; tick;
    start = 4'b0011;
    for (int c = 0; c < 14; c++) begin
      tick;
      chk($sformatf("par ch0 c%0d", c), 32'(trigger[0]), 32'((c % 2) == 0));
      chk($sformatf("par ch1 trig c%0d", c), 32'(trigger[1]), 32'(tbl[2].trig[c] == "1"));
      chk($sformatf("par ch1 done c%0d", c), 32'(done[1]), 32'(tbl[2].dn[c] == "1"));
      chk($sformatf("par done0 c%0d", c), 32'(done[0]), 32'h0);
    end
    start = '0;
    tick; tick;

    // Asynchronous reset mid-run, then restart with fresh registers
    cfg(0, 0, 2, 3, 0);
    cfg(2, 0, 0, 2, 1);
    tick; tick;
    start = 4'b0101;
    tick;
    tick;
    chk("pre_rst_trig0", 32'(trigger[0]), 32'h1);
    chk("pre_rst_done2", 32'(done[2]), 32'h1);
    #2 aresetn = 1'b0;
    #1;
    chk("async_rst_trig", 32'(trigger), 32'h0);
    chk("async_rst_done", 32'(done), 32'h0);
    cfg(0, 0, 1, 3, 0);
    tick;
    chk("held_rst_trig", 32'(trigger), 32'h0);
    chk("held_rst_done", 32'(done), 32'h0);
    #2 aresetn = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick;
      chk($sformatf("post_rst ch0 c%0d", c), 32'(trigger[0]), 32'((c < 2) || (c == 6)));
    end
    start = '0;
    tick;
    chk("final_idle_trig", 32'(trigger), 32'h0);
    chk("final_idle_done", 32'(done), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
